// File: rtl/bpred_pkg.sv
// Shared types for the branch predictor: branch kinds, 2-bit counter levels
// and the BTB entry layout (the tag lives in a separate array so TAG_W stays a top parameter).
package bpred_pkg;

  typedef enum logic [1:0] {
    COND   = 2'd0,
    UNCOND = 2'd1,
    CALL   = 2'd2,
    RET    = 2'd3
  } br_kind_t;

  localparam logic [1:0] STRONG_NT = 2'd0;
  localparam logic [1:0] WEAK_NT   = 2'd1;
  localparam logic [1:0] WEAK_T    = 2'd2;
  localparam logic [1:0] STRONG_T  = 2'd3;

  typedef struct packed {
    logic        valid;
    br_kind_t    kind;
    logic [1:0]  ctr;
    logic [63:0] target;
  } btb_entry_t;

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != STRONG_T)
      nxt = ctr + 2'd1;
    else if (!taken && ctr != STRONG_NT)
      nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_ras.sv
// Speculative return-address stack: circular buffer, a push when full overwrites
// the oldest entry; a pop when empty is ignored.
module bpred_ras #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  logic        pop,
  input  logic [63:0] push_data,
  output logic [63:0] top,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [63:0]    stack_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] top_idx;

  // ptr_q is the next free slot; the top sits just below it
  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = stack_q[top_idx];
  assign empty   = (count_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[ptr_q] <= push_data;
      ptr_q          <= ptr_q + PTR_W'(1);
      if (count_q != (PTR_W+1)'(DEPTH)) count_q <= count_q + (PTR_W+1)'(1);
    end else if (pop && !empty) begin
      ptr_q   <= top_idx;
      count_q <= count_q - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters and a saturating mispredict counter.
// Optional return-address stack compiled in with `define BPRED_RAS_EN.
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int ENTRIES   = 16,
  parameter int TAG_W     = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lookup_valid_IF,
  input  logic [63:0] PC_IF,
  output logic        pred_taken_IF,
  output logic [63:0] pred_target_IF,
  input  logic        upd_valid_EX,
  input  logic [63:0] upd_pc_EX,
  input  logic        upd_taken_EX,
  input  logic [63:0] upd_target_EX,
  input  logic [1:0]  upd_kind_EX,
  input  logic        upd_mispred_EX,
  output logic [31:0] mispred_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LSB = IDX_W + 2;

  btb_entry_t       btb_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  btb_entry_t       lk_e;
  logic             lk_hit, up_hit;
  logic [63:0]      pc_plus4;

  assign lk_idx   = PC_IF[TAG_LSB-1:2];
  assign lk_tag   = PC_IF[TAG_LSB +: TAG_W];
  assign up_idx   = upd_pc_EX[TAG_LSB-1:2];
  assign up_tag   = upd_pc_EX[TAG_LSB +: TAG_W];
  assign lk_e     = btb_q[lk_idx];
  assign lk_hit   = lk_e.valid && (tag_q[lk_idx] == lk_tag);
  assign up_hit   = btb_q[up_idx].valid && (tag_q[up_idx] == up_tag);
  assign pc_plus4 = PC_IF + 64'd4;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC_IF[63:TAG_LSB+TAG_W], PC_IF[1:0],
                            upd_pc_EX[63:TAG_LSB+TAG_W], upd_pc_EX[1:0]};

`ifdef BPRED_RAS_EN
  logic [63:0] ras_top;
  logic        ras_empty;
  logic        ras_push, ras_pop;

  assign ras_push = pred_taken_IF && (lk_e.kind == CALL);
  assign ras_pop  = pred_taken_IF && (lk_e.kind == RET);

  bpred_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`endif

  always_comb begin
    pred_taken_IF  = lookup_valid_IF && lk_hit && ((lk_e.kind != COND) || lk_e.ctr[1]);
    pred_target_IF = lk_hit ? lk_e.target : pc_plus4;
`ifdef BPRED_RAS_EN
    if (pred_taken_IF && (lk_e.kind == RET) && !ras_empty) pred_target_IF = ras_top;
`endif
  end

  // Lookup reads the registered table, so a same-index update is not bypassed
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, kind: COND, ctr: WEAK_NT, target: 64'd0};
        tag_q[i] <= '0;
      end
    end else if (upd_valid_EX) begin
      if (up_hit) begin
        if (btb_q[up_idx].kind == COND)
          btb_q[up_idx].ctr <= ctr_step(btb_q[up_idx].ctr, upd_taken_EX);
        if (upd_taken_EX)
          btb_q[up_idx].target <= upd_target_EX;
      end else if (upd_taken_EX) begin
        btb_q[up_idx] <= '{valid: 1'b1, kind: br_kind_t'(upd_kind_EX),
                           ctr: WEAK_T, target: upd_target_EX};
        tag_q[up_idx] <= up_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      mispred_count <= '0;
    else if (upd_valid_EX && upd_mispred_EX && (mispred_count != 32'hFFFF_FFFF))
      mispred_count <= mispred_count + 32'd1;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of direct-mapped BTB entries (power of 2, range 4..256).
REQ-002 The block SHALL have parameter TAG_W, default 8, giving the number of PC tag bits stored per entry, taken from PC above the index bits.
REQ-003 The block SHALL have parameter RAS_DEPTH, default 4, giving the return-address-stack depth (power of 2); it is used only when the RAS is compiled in.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port lookup_valid_IF, input, 1 bit: a fetch lookup is live this cycle.
REQ-007 The block SHALL have port PC_IF, input, 64 bits: the fetch PC.
REQ-008 The block SHALL have port pred_taken_IF, output, 1 bit: predict taken; combinational from PC_IF and state.
REQ-009 The block SHALL have port pred_target_IF, output, 64 bits: the predicted target; combinational.
REQ-010 The block SHALL have port upd_valid_EX, input, 1 bit: a resolved branch is presented this cycle.
REQ-011 The block SHALL have port upd_pc_EX, input, 64 bits: the PC of the resolved branch.
REQ-012 The block SHALL have port upd_taken_EX, input, 1 bit: the resolved direction.
REQ-013 The block SHALL have port upd_target_EX, input, 64 bits: the resolved target.
REQ-014 The block SHALL have port upd_kind_EX, input, 2 bits: branch kind, one of COND (B.cond/CBZ/CBNZ), UNCOND (B), CALL (BL), RET (BR).
REQ-015 The block SHALL have port upd_mispred_EX, input, 1 bit: the resolved branch was mispredicted.
REQ-016 The block SHALL have port mispred_count, output, 32 bits: a saturating mispredict counter.

Function
REQ-017 Index SHALL be PC[$clog2(ENTRIES)+1:2]; tag SHALL be the next TAG_W bits; hit SHALL mean the entry is valid and its tag matches.
REQ-018 pred_taken_IF SHALL be hit AND (kind != COND OR counter[1]); it SHALL be 0 when lookup_valid_IF=0.
REQ-019 pred_target_IF SHALL be the stored target on a hit and PC_IF+4 otherwise; the RET override is defined in REQ-029.
REQ-020 Lookup SHALL be zero-latency combinational; update SHALL take effect at the next rising edge.
REQ-021 On an update that hits, a COND entry's 2-bit counter SHALL increment on taken and decrement on not-taken, saturating at 3 and 0.
REQ-022 On an update that hits with taken=1, the stored target SHALL be overwritten with upd_target_EX.
REQ-023 On an update that misses with taken=1, the entry SHALL be allocated or replaced: valid=1, tag, target and kind written, counter=2'b10.
REQ-024 On an update that misses with taken=0, the table SHALL NOT be modified.
REQ-025 When lookup and update address the same index in the same cycle, the lookup SHALL see the pre-update contents (no bypass).
REQ-026 mispred_count SHALL increment by 1 on each cycle with upd_valid_EX && upd_mispred_EX, and SHALL hold at 32'hFFFF_FFFF.

Reset
REQ-027 While reset_n=0: all valid bits SHALL be 0, counters SHALL be 2'b01, mispred_count SHALL be 0, and the RAS SHALL be empty (ptr=0, count=0).
REQ-028 Outputs during and directly after reset SHALL be pred_taken_IF=0 and pred_target_IF=PC_IF+4; reset asserted mid-update SHALL discard that update.

Configuration
REQ-029 With macro BPRED_RAS_EN defined: a RAS of RAS_DEPTH entries SHALL exist; a predicted-taken CALL lookup SHALL push PC_IF+4; a predicted-taken RET lookup SHALL pop, and pred_target_IF SHALL equal the RAS top when the RAS is non-empty.
REQ-030 With BPRED_RAS_EN defined, a push when full SHALL overwrite the oldest entry (circular pointer, count saturates at RAS_DEPTH).
REQ-031 With BPRED_RAS_EN defined, a RET lookup when the RAS is empty SHALL leave the RAS unchanged and use the BTB target.
REQ-032 With BPRED_RAS_EN defined, the RAS SHALL change only when lookup_valid_IF=1; it is speculative and SHALL NOT be repaired on mispredict.
REQ-033 Without BPRED_RAS_EN: no RAS logic SHALL exist, and RET SHALL be predicted from the BTB target like UNCOND.

Structure
REQ-034 Package bpred_pkg SHALL hold the br_kind_t enum (COND=0, UNCOND=1, CALL=2, RET=3), the counter constants (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3) and the BTB entry struct.
REQ-035 The RAS SHALL be a sub-module bpred_ras (push, pop, top, empty), instantiated only under BPRED_RAS_EN.

Verification
REQ-036 Reset, then a lookup at PC=0x100 SHALL give pred_taken_IF=0 and pred_target_IF=0x104.
REQ-037 Update pc=0x100, COND, taken=1, target=0x40; a subsequent lookup at 0x100 SHALL give taken=1, target=0x40; two not-taken updates SHALL then give taken=0.
REQ-038 Four taken updates to one COND entry SHALL saturate the counter at 3; a single not-taken update SHALL leave the prediction taken.
REQ-039 Aliasing: update 0x100 then 0x100+4*ENTRIES (same index, different tag); a lookup at 0x100 SHALL then miss.
REQ-040 With BPRED_RAS_EN: predicted CALL at 0x200, then RET lookup SHALL give target 0x204; RAS_DEPTH+1 pushes then RAS_DEPTH+1 pops SHALL give the oldest entry lost and the final pop using the BTB target.
REQ-041 Apply 5 mispredicts, then assert reset_n=0 mid-stream; mispred_count SHALL read 5 before reset, 0 after, and the table SHALL be all-invalid.
